// File: rtl/ip_codma_mem_responder_if.sv
// ip_codma_mem_responder_if: CODMA memory request/response bundle between DMA master and memory responder
interface ip_codma_mem_responder_if;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [3:0]  size;
  logic        grant;
  logic [63:0] read_data;
  logic        read_valid;
  logic [63:0] write_data;
  logic        write_valid;
  logic        error;
  modport master (output read, write, addr, size, write_data, write_valid, input grant, read_data, read_valid, error);
  modport slave (input read, write, addr, size, write_data, write_valid, output grant, read_data, read_valid, error);
endinterface

// File: rtl/ip_codma_mem_responder.sv
// ip_codma_mem_responder: CODMA memory-side burst responder over a 64-bit word array; IP_CODMA_MEM_STALL_EN adds a pseudo-random pre-grant stall
module ip_codma_mem_responder #(
  parameter int          DEPTH        = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 2
) (
  input logic clk_i,
  input logic reset_i,
  ip_codma_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] WL = 3'(READ_LATENCY - 1);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA
`ifdef IP_CODMA_MEM_STALL_EN
    , STALL
`endif
  } state_t;
  state_t state;
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [3:0] cnt;
  logic [2:0] wcnt;
  logic grant_q, error_q, rv_q;
  logic [63:0] rd_q;
  logic [32:0] off, last;
  logic req, legal, emit, we;
  assign off = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
  assign last = (off >> 3) + 33'(bus.size);
  assign legal = bus.addr[2:0] == 3'd0 && bus.addr >= BASE_ADDR && bus.size != 4'd0 && last <= 33'(DEPTH);
  assign req = bus.read | bus.write;
  assign emit = (state == RD_WAIT && wcnt == 3'd0) || (state == RD_DATA && cnt != 4'd0);
  assign we = state == WR_DATA && bus.write_valid && !grant_q && !reset_i;
  assign bus.grant = grant_q;
  assign bus.error = error_q;
  assign bus.read_valid = rv_q;
  assign bus.read_data = rd_q;
`ifdef IP_CODMA_MEM_STALL_EN
  logic [3:0] lfsr;
  logic is_rd;
  // Free-running x^4+x^3+1 LFSR choosing the pre-grant stall length
  always_ff @(posedge clk_i) lfsr <= reset_i ? 4'b1001 : {lfsr[2:0], lfsr[3] ^ lfsr[2]};
`endif
  // Backing store; contents deliberately survive reset
  always_ff @(posedge clk_i) if (we) mem[idx] <= bus.write_data;
  // Request sequencing, beat counting and registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      grant_q <= 1'b0;
      error_q <= 1'b0;
      rv_q <= 1'b0;
      rd_q <= '0;
      idx <= '0;
      cnt <= '0;
      wcnt <= '0;
    end else begin
      grant_q <= 1'b0;
      error_q <= 1'b0;
      rv_q <= emit;
      if (emit) rd_q <= mem[idx];
      if (emit || we) begin
        idx <= idx + 1'b1;
        cnt <= cnt - 4'd1;
      end
      case (state)
        IDLE: if (req) begin
          if (!legal) error_q <= 1'b1;
          else begin
            idx <= off[AW+2:3];
            cnt <= bus.size;
            wcnt <= WL;
`ifdef IP_CODMA_MEM_STALL_EN
            is_rd <= bus.read;
            if (lfsr[1:0] != 2'd0) begin
              state <= STALL;
              wcnt <= {1'b0, lfsr[1:0] - 2'd1};
            end else begin
              grant_q <= 1'b1;
              state <= bus.read ? RD_WAIT : WR_DATA;
            end
`else
            grant_q <= 1'b1;
            state <= bus.read ? RD_WAIT : WR_DATA;
`endif
          end
        end
`ifdef IP_CODMA_MEM_STALL_EN
        STALL: if (wcnt == 3'd0) begin
          grant_q <= 1'b1;
          wcnt <= WL;
          state <= is_rd ? RD_WAIT : WR_DATA;
        end else wcnt <= wcnt - 3'd1;
`endif
        RD_WAIT: if (wcnt == 3'd0) state <= RD_DATA; else wcnt <= wcnt - 3'd1;
        RD_DATA: if (cnt == 4'd0) state <= IDLE;
        WR_DATA: if (we && cnt == 4'd1) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ip_codma_mem_responder.sv
// tb_ip_codma_mem_responder: randomized burst bench against a transaction-level memory model
module tb_ip_codma_mem_responder;
  localparam int DEPTH = 64;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int RL = 2;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic [63:0] ref_mem [DEPTH];
  int checks = 0;
  int failures = 0;
  ip_codma_mem_responder_if bus();
  ip_codma_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(RL)) dut (.clk_i(clk_i), .reset_i(reset_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  function automatic bit legal_f(input logic [31:0] a, input int s);
    longint off;
    off = longint'({32'd0, a}) - longint'({32'd0, BASE});
    return a[2:0] == 3'd0 && off >= 0 && s != 0 && off / 8 + s <= DEPTH;
  endfunction
  task automatic read_phase(input int idx, input int s);
    for (int k = 2; k <= RL + s + 1; k++) begin
      bit ev;
      tick();
      ev = k >= RL + 1 && k <= RL + s;
      check("rd_valid", bus.read_valid, 64'(ev));
      if (ev) check("rd_data", bus.read_data, ref_mem[idx + k - RL - 1]);
      else if (k > RL + s) check("rd_hold", bus.read_data, ref_mem[idx + s - 1]);
      check("rd_grant_quiet", bus.grant, 0);
    end
  endtask
  task automatic write_phase(input int idx, input int s, input logic [15:0] pat, input bit fixed);
    int n;
    n = 0;
    bus.write_valid = 1'b1;
    bus.write_data = {$urandom, $urandom};
    tick();
    for (int i = 0; i < 200 && n < s; i++) begin
      bit v;
      v = (pat != 16'd0 && i < 16) ? pat[i] : ($urandom_range(0, 2) != 0);
      bus.write_valid = v;
      bus.write_data = fixed ? 64'(n + 1) * 64'h11 : {$urandom, $urandom};
      tick();
      check("wr_grant_quiet", bus.grant, 0);
      if (v) begin
        ref_mem[idx + n] = bus.write_data;
        n++;
      end
    end
    check("wr_beats", 64'(n), 64'(s));
    bus.write_valid = 1'b1;
    bus.write_data = {$urandom, $urandom};
    tick();
    bus.write_valid = 1'b0;
  endtask
  task automatic burst(input bit rd, input logic [31:0] a, input int s, input logic [15:0] pat, input bit fixed);
    bit ok;
    int idx;
    ok = legal_f(a, s);
    idx = int'((a - BASE) >> 3);
    bus.read = rd;
    bus.write = !rd;
    bus.addr = a;
    bus.size = 4'(s);
    bus.write_valid = 1'b1;
    bus.write_data = {$urandom, $urandom};
    tick();
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.write_valid = 1'b0;
    check(rd ? "rd_grant" : "wr_grant", bus.grant, 64'(ok));
    check("req_error", bus.error, 64'(!ok));
    check("t1_rvalid", bus.read_valid, 0);
    if (!ok) begin
      tick();
      check("error_pulse", bus.error, 0);
      check("error_no_grant", bus.grant, 0);
      check("error_no_rvalid", bus.read_valid, 0);
    end else if (rd) read_phase(idx, s);
    else write_phase(idx, s, pat, fixed);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] a;
    int r;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.addr = '0;
    bus.size = '0;
    bus.write_data = '0;
    bus.write_valid = 1'b0;
    repeat (3) tick();
    check("rst_grant", bus.grant, 0);
    check("rst_error", bus.error, 0);
    check("rst_rvalid", bus.read_valid, 0);
    check("rst_rdata", bus.read_data, 0);
    reset_i = 1'b0;
    tick();
    for (int w = 0; w < DEPTH; w += 15) burst(1'b0, BASE + 32'(w * 8), (DEPTH - w < 15) ? DEPTH - w : 15, 16'd0, 1'b0);
    burst(1'b0, BASE + 32'h40, 4, 16'd0, 1'b1);
    burst(1'b1, BASE + 32'h40, 4, 16'd0, 1'b0);
    burst(1'b1, BASE + 32'h44, 4, 16'd0, 1'b0);
    burst(1'b1, BASE + 32'h40, 0, 16'd0, 1'b0);
    burst(1'b1, BASE - 32'h8, 1, 16'd0, 1'b0);
    burst(1'b1, BASE + 32'((DEPTH - 2) * 8), 3, 16'd0, 1'b0);
    burst(1'b1, BASE + 32'((DEPTH - 2) * 8), 2, 16'd0, 1'b0);
    bus.read = 1'b1;
    bus.write = 1'b1;
    bus.addr = BASE;
    bus.size = 4'd3;
    tick();
    check("both_rd_grant", bus.grant, 1);
    bus.read = 1'b0;
    read_phase(0, 3);
    tick();
    check("held_wr_grant", bus.grant, 1);
    bus.write = 1'b0;
    write_phase(0, 3, 16'd0, 1'b0);
    burst(1'b1, BASE, 4, 16'd0, 1'b0);
    burst(1'b0, BASE + 32'(30 * 8), 3, 16'h0019, 1'b0);
    burst(1'b1, BASE + 32'(30 * 8), 4, 16'd0, 1'b0);
    bus.read = 1'b1;
    bus.addr = BASE + 32'(20 * 8);
    bus.size = 4'd8;
    tick();
    check("rst_case_grant", bus.grant, 1);
    bus.read = 1'b0;
    for (int k = 2; k <= RL + 2; k++) tick();
    check("rst_case_beat2", bus.read_valid, 1);
    check("rst_case_data2", bus.read_data, ref_mem[21]);
    reset_i = 1'b1;
    tick();
    check("midrst_rvalid", bus.read_valid, 0);
    check("midrst_rdata", bus.read_data, 0);
    check("midrst_grant", bus.grant, 0);
    check("midrst_error", bus.error, 0);
    reset_i = 1'b0;
    repeat (4) begin
      tick();
      check("postrst_rvalid", bus.read_valid, 0);
    end
    burst(1'b1, BASE + 32'(20 * 8), 8, 16'd0, 1'b0);
    repeat (60) begin
      r = $urandom_range(0, 9);
      a = BASE + 32'($urandom_range(0, DEPTH * 8 + 64));
      if (r >= 3) a[2:0] = 3'd0;
      if (r == 0) a = BASE - 32'(8 * $urandom_range(1, 8));
      burst(1'($urandom_range(0, 1)), a, $urandom_range(0, 15), 16'd0, 1'b0);
    end
    for (int w = 0; w < DEPTH; w += 15) burst(1'b1, BASE + 32'(w * 8), (DEPTH - w < 15) ? DEPTH - w : 15, 16'd0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
